// File: rtl/pid_seq_pkg.sv
// pid_seq shared types, widths and saturation helpers.
// Used by pid_seq and pid_mult.
package pid_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL_P,
    MUL_D,
    SUM
  } state_e;

  localparam int ERR_W  = 11;
  localparam int PROD_W = 17;
  localparam int PID_W  = 16;

  localparam logic signed [11:0] D_SAT_MAX = 12'sd127;
  localparam logic signed [11:0] D_SAT_MIN = -12'sd128;
  localparam logic signed [17:0] PID_MAX   = 18'sd32767;
  localparam logic signed [17:0] PID_MIN   = -18'sd32768;

  function automatic logic signed [7:0] sat8(
    input logic signed [11:0] v
  );
    if (v > D_SAT_MAX)      return D_SAT_MAX[7:0];
    else if (v < D_SAT_MIN) return D_SAT_MIN[7:0];
    else                    return v[7:0];
  endfunction

  function automatic logic signed [PID_W-1:0] sat16(
    input logic signed [17:0] v
  );
    if (v > PID_MAX)      return PID_MAX[PID_W-1:0];
    else if (v < PID_MIN) return PID_MIN[PID_W-1:0];
    else                  return v[PID_W-1:0];
  endfunction

endpackage

// File: rtl/pid_mult.sv
// Shared registered multiplier: signed 11b x unsigned 6b.
// Product is 17b signed, valid one clock after the operands.
module pid_mult
  import pid_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ERR_W-1:0]  a,
  input  logic [5:0]               b,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] a_x;
  logic signed [PROD_W-1:0] b_x;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;

  // widen both operands so the product cannot overflow 17 bits
  always_comb begin
    a_x    = {{(PROD_W-ERR_W){a[ERR_W-1]}}, a};
    b_x    = {{(PROD_W-6){1'b0}}, b};
    prod_d = a_x * b_x;
  end

  // product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else        prod_q <= prod_d;
  end

  assign prod = prod_q;

endmodule

// File: rtl/pid_seq.sv
// PD sequencer: one shared multiplier, P then D, then sum.
// PID_SATCNT_EN adds the sat_cnt clamp-event counter.
module pid_seq
  import pid_seq_pkg::*;
#(
  parameter logic [5:0] P_COEFF = 6'h08,
  parameter logic [5:0] D_COEFF = 6'h38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  output logic signed [PID_W-1:0] PID,
  output logic                    pid_vld,
  output logic                    busy
`ifdef PID_SATCNT_EN
  ,
  output logic [7:0]              sat_cnt
`endif
);

  state_e state_q, state_d;
  logic signed [ERR_W-1:0]  cur_q, cur_d;
  logic signed [ERR_W-1:0]  prev_q, prev_d;
  logic signed [ERR_W-1:0]  pend_q, pend_d;
  logic                     pend_vld_q, pend_vld_d;
  logic signed [ERR_W:0]    diff_q, diff_d;
  logic signed [PROD_W-1:0] p_prod_q, p_prod_d;
  logic signed [PID_W-1:0]  pid_q, pid_d;
  logic                     vld_q, vld_d;
  logic                     busy_q, busy_d;

  logic signed [ERR_W-1:0]  mul_a;
  logic [5:0]               mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W:0]   sum;
  logic signed [7:0]        d_sat;
  logic                     load;
  logic signed [ERR_W-1:0]  src;

  // operand select for the shared multiplier
  always_comb begin
    d_sat = sat8(diff_q);
    if (state_q == MUL_D) begin
      mul_a = {{(ERR_W-8){d_sat[7]}}, d_sat};
      mul_b = D_COEFF;
    end else begin
      mul_a = cur_q;
      mul_b = P_COEFF;
    end
  end

  pid_mult u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mul_a),
    .b     (mul_b),
    .prod  (prod)
  );

  // next-state, sample loading and sum/saturate
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    diff_d     = diff_q;
    p_prod_d   = p_prod_q;
    pid_d      = pid_q;
    vld_d      = 1'b0;
    busy_d     = busy_q;
    load       = 1'b0;
    src        = err_sat;
    sum        = {p_prod_q[PROD_W-1], p_prod_q}
               + {prod[PROD_W-1], prod};
    unique case (state_q)
      IDLE: begin
        if (err_vld) load = 1'b1;
      end
      MUL_P: begin
        if (err_vld) begin
          pend_d     = err_sat;
          pend_vld_d = 1'b1;
        end
        state_d = MUL_D;
      end
      MUL_D: begin
        if (err_vld) begin
          pend_d     = err_sat;
          pend_vld_d = 1'b1;
        end
        p_prod_d = prod;
        state_d  = SUM;
      end
      SUM: begin
        pid_d = sat16(sum);
        vld_d = 1'b1;
        if (err_vld || pend_vld_q) begin
          load       = 1'b1;
          src        = err_vld ? err_sat : pend_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
    if (load) begin
      cur_d   = src;
      diff_d  = {src[ERR_W-1], src} - {prev_q[ERR_W-1], prev_q};
      prev_d  = src;
      busy_d  = 1'b1;
      state_d = MUL_P;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      diff_q     <= '0;
      p_prod_q   <= '0;
      pid_q      <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      diff_q     <= diff_d;
      p_prod_q   <= p_prod_d;
      pid_q      <= pid_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
    end
  end

  assign PID     = pid_q;
  assign pid_vld = vld_q;
  assign busy    = busy_q;

`ifdef PID_SATCNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       sat_hit;

  // count clamp events, sticky at 255
  always_comb begin
    cnt_d   = cnt_q;
    sat_hit = (sum > PID_MAX) || (sum < PID_MIN);
    if (state_q == SUM && sat_hit && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  // clamp counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_cnt = cnt_q;
`endif

endmodule

// File: doc/pid_seq.md
Name: pid_seq

Overview:
- Sequencer for the PD control datapath. On each valid saturated error sample it schedules one shared multiplier through the P and D products.
- D path: derivative of error, saturated to 8 bits, times D_COEFF, same arithmetic as D_term.
- Sums P and D, saturates the sum and emits a one-cycle-valid PID command.
- Sits between the error-saturation stage and the motor-drive mixer.

Parameters:
- P_COEFF, 6'h08: unsigned proportional coefficient.
- D_COEFF, 6'h38: unsigned derivative coefficient.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- err_sat  in  11  signed saturated error
- err_vld  in  1  err_sat valid, sampled on rising clk
- PID  out  16  signed saturated P+D command
- pid_vld  out  1  one-cycle pulse when PID updates
- busy  out  1  high while a sample is in flight
- (macro only) sat_cnt  out  8  PID saturation event count

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous, active-low. Reset is fixed; every flop clears immediately when rst_n=0.
- Reset values:
  - Outputs PID=0, pid_vld=0, busy=0, sat_cnt=0.
  - Internal state=IDLE, prev_err=0, pending empty.
- States: IDLE, MUL_P, MUL_D, SUM.
- IDLE: err_vld=1 at edge N causes all of the following at edge N:
  - cur_err <= err_sat.
  - diff <= err_sat - prev_err, 12-bit signed.
  - prev_err <= err_sat.
  - busy <= 1.
  - state -> MUL_P.
- MUL_P: multiplier operands are cur_err and P_COEFF. The registered product is captured into p_prod, 17-bit signed. State -> MUL_D.
- MUL_D: multiplier operands are sat8(diff), sign-extended to 11 bits, and D_COEFF. Product is captured into d_prod. State -> SUM.
- sat8: values > 127 become 127; values < -128 become -128; otherwise pass through.
- SUM, at edge N+3:
  - PID <= sat16(p_prod + d_prod). The sum is 18-bit signed; clamp to 32767 / -32768.
  - pid_vld <= 1 for exactly one cycle.
  - If pending is full: load it as in IDLE, clear pending, state -> MUL_P, busy stays 1.
  - If pending is empty: state -> IDLE, busy <= 0.
- Latency: PID and pid_vld update 3 clocks after the capturing edge. PID holds its value between updates.
- err_vld while busy (MUL_P/MUL_D/SUM): the sample goes into the one-deep pending register. The newest sample overwrites an older pending one. prev_err is not updated until the pending sample is loaded.
- err_vld in SUM with pending empty: the sample is captured into pending and processed immediately afterwards, with no IDLE cycle.
- Held input: err_vld held continuously high gives a PID every 3 cycles. D is 0 after the first sample if err_sat is constant.
- Reset mid-operation: the in-flight and pending samples are discarded, and no pid_vld is emitted.

Optional Feature:
- Macro PID_SATCNT_EN.
- Defined: the sat_cnt port exists. It increments by 1 each SUM cycle in which sat16 clamps, and sticks at 255 with no wrap. It clears only on reset.
- Undefined: the port and counter are absent. The remaining behaviour is identical.

Decomposition:
- Package pid_seq_pkg:
  - state enum typedef.
  - Width constants ERR_W=11, PROD_W=17, PID_W=16.
  - Limit constants D_SAT_MAX=127, D_SAT_MIN=-128, PID_MAX=32767, PID_MIN=-32768.
- Sub-module pid_mult: signed 11-bit by unsigned 6-bit registered multiplier with a 17-bit signed product.
  - Inputs clk, rst_n, a, b. Output prod.
  - Instantiated once and shared between the P and D states.

Test Plan:
- Reset, err_vld=0 for 5 clocks -> PID=0, pid_vld=0, busy=0 throughout.
- err_sat=0x030 pulse after reset -> 3 clocks later pid_vld=1, PID=0x0C00 (P 0x180 + D 0xA80).
- Then err_sat=0x0B0 -> diff 0x80 saturates to 0x7F; D=0x1BC8, P=0x580, PID=0x2148.
- Then err_sat=0x700 -> diff -432 saturates to -128; D=-7168, P=-2048, PID=0xDC00.
- Instance with P_COEFF=6'h3F, err_sat 0 then 0x3FF -> PID=0x7FFF; sat_cnt=1 with PID_SATCNT_EN.
- err_vld held high with err_sat=0x040 for 9 clocks:
  - pid_vld pulses every 3 clocks with busy stuck high.
  - First PID=0x0F00, later PIDs=0x0200.
- Reset asserted in MUL_D -> no pid_vld, PID=0, busy=0.
